// File: rtl/fnd_pkg.sv
// fnd_pkg: shared definitions for the FND scan controller.
//   SEG_OFF  - all segments dark (active-low)
//   HEX_SEG  - hex digit to active-low {g,f,e,d,c,b,a} pattern table
//   phase_t  - slot phase: BLANK (dead time) or DRIVE (digit lit)
package fnd_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Index = hex value, entry = active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_t;

endpackage

// File: rtl/fnd_seg_decoder.sv
// fnd_seg_decoder: combinational hex nibble to 7-segment decoder.
//   nibble in  4  hex value 0..F
//   seg    out 7  active-low {g,f,e,d,c,b,a}
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed scan controller for common-anode FND modules.
// Scans DIGITS digits, SCAN_DIV cycles per slot, with BLANK_CYCLES of dead
// time at the start of every slot. Display data is snapshotted once per frame
// so a frame never mixes old and new values.
//
// Parameters: DIGITS (2..8), SCAN_DIV (>=4), BLANK_CYCLES (1..SCAN_DIV-2)
// Ports:
//   i_clk         in   system clock, rising edge
//   i_reset       in   synchronous active-high reset (wins over i_en)
//   i_en          in   scan enable; low blanks display and restarts the scan
//   i_value       in   4*DIGITS  hex nibble per digit, digit 0 = LSBs
//   i_dp          in   DIGITS    decimal point request per digit
//   o_digit       out  DIGITS    active-low one-cold digit select
//   o_seg         out  8         active-low {dp,g,f,e,d,c,b,a}
//   o_frame_tick  out  1         one-cycle pulse at each frame start
//
// Build option: define FND_LEADING_ZERO_BLANK_EN to suppress leading zero
// digits (digit 0 is always shown).
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [DIGITS-1:0]     o_digit,
  output logic [7:0]            o_seg,
  output logic                  o_frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE    = DIGITS'(1);

  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  phase_t              phase_reg;
  logic [4*DIGITS-1:0] value_snap_reg;
  logic [DIGITS-1:0]   dp_snap_reg;
  logic [DIGITS-1:0]   digit_reg;
  logic [7:0]          seg_reg;
  logic                tick_reg;

  logic                frame_start;
  logic                slot_end;
  logic                blank_end;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_seg7;
  logic                digit_suppressed;

  // The first cycle of slot 0 is the frame start. While disabled the counters
  // sit at zero, so the first enabled cycle is a frame start too.
  assign frame_start = (cnt_reg == '0) && (idx_reg == '0);
  assign slot_end    = (cnt_reg == CNT_LAST);
  assign blank_end   = (cnt_reg == BLANK_LAST);
  assign cur_nibble  = value_snap_reg[{idx_reg, 2'b00} +: 4];

  fnd_seg_decoder u_seg_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg7)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  // lz_mask[k]: nibble k and every nibble above it are zero.
  logic [DIGITS-1:0] lz_mask;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_mask[gi] = 1'b0;
      end else begin : g_upper
        assign lz_mask[gi] = (value_snap_reg[4*DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  assign digit_suppressed = lz_mask[idx_reg];
`else
  assign digit_suppressed = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      phase_reg      <= BLANK;
      value_snap_reg <= '0;
      dp_snap_reg    <= '0;
      digit_reg      <= '1;
      seg_reg        <= SEG_OFF;
      tick_reg       <= 1'b0;
    end else if (!i_en) begin
      // Park at the start of digit 0; snapshots are refreshed on re-enable.
      cnt_reg   <= '0;
      idx_reg   <= '0;
      phase_reg <= BLANK;
      digit_reg <= '1;
      seg_reg   <= SEG_OFF;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= frame_start;
      if (frame_start) begin
        value_snap_reg <= i_value;
        dp_snap_reg    <= i_dp;
      end

      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      case (phase_reg)
        BLANK:   if (blank_end) phase_reg <= DRIVE;
        DRIVE:   if (slot_end)  phase_reg <= BLANK;
        default: phase_reg <= BLANK;
      endcase

      // Outputs follow the current phase one cycle later.
      if ((phase_reg == DRIVE) && !digit_suppressed) begin
        digit_reg <= ~(DIG_ONE << idx_reg);
        seg_reg   <= {~dp_snap_reg[idx_reg], cur_seg7};
      end else begin
        digit_reg <= '1;
        seg_reg   <= SEG_OFF;
      end
    end
  end

  assign o_digit      = digit_reg;
  assign o_seg        = seg_reg;
  assign o_frame_tick = tick_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: self-checking bench for fnd_scan_ctrl with DIGITS=4,
// SCAN_DIV=8, BLANK_CYCLES=2. A frame-position model predicts every output
// cycle; a run monitor records each lit-digit interval and each frame tick so
// directed checks can pin scan order, durations, gaps and tick spacing.
module tb_fnd_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  o_digit;
  logic [7:0]  o_seg;
  logic        o_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  fnd_scan_ctrl #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_value      (value),
    .i_dp         (dp),
    .o_digit      (o_digit),
    .o_seg        (o_seg),
    .o_frame_tick (o_tick)
  );

  always #5 clk = ~clk;

  // Segment table written out from the display's hex glyph list.
  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- behavioural model ----------------
  // k = cycles since the scan (re)started; slot and in-slot position follow
  // directly from k, and the snapshot is refreshed whenever k is a frame start.
  int          cyc = 0;
  int          k = 0;
  bit          running = 0;
  bit          model_valid = 0;
  logic [15:0] snap_v = '0;
  logic [3:0]  snap_dp = '0;
  logic [3:0]  e_dig;
  logic [7:0]  e_seg;
  logic        e_tick;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        running = 0; snap_v = '0; snap_dp = '0;
        e_dig = 4'hF; e_seg = 8'hFF; e_tick = 1'b0;
      end else if (!en) begin
        running = 0;
        e_dig = 4'hF; e_seg = 8'hFF; e_tick = 1'b0;
      end else begin
        int slot, pos;
        logic [15:0] upper;
        bit shown;
        k = running ? (k + 1) % FRAME : 0;
        running = 1;
        if (k == 0) begin
          snap_v  = value;
          snap_dp = dp;
        end
        e_tick = (k == 0);
        slot   = k / SCAN_DIV;
        pos    = k % SCAN_DIV;
        upper  = snap_v >> (4 * slot);
        shown  = (pos >= BLANK);
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (slot > 0 && upper == 16'h0) shown = 0;
`endif
        if (shown) begin
          e_dig = ~(4'b0001 << slot);
          e_seg = {~snap_dp[slot], hex_tab[upper[3:0]]};
        end else begin
          e_dig = 4'hF;
          e_seg = 8'hFF;
        end
      end
      model_valid = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_print = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        n_cmp = n_cmp + 1;
        if (o_digit !== e_dig || o_seg !== e_seg || o_tick !== e_tick) begin
          n_fail = n_fail + 1;
          if (n_print < 20) begin
            n_print = n_print + 1;
            $display("FAIL cycle_compare cyc=%0d: got digit=%h seg=%h tick=%b, expected digit=%h seg=%h tick=%b",
                     cyc, o_digit, o_seg, o_tick, e_dig, e_seg, e_tick);
          end
        end
      end
    end
  end

  // ---------------- run / tick monitor ----------------
  int   run_dig_q[$];
  int   run_seg_q[$];
  int   run_len_q[$];
  int   run_start_q[$];
  int   tick_q[$];
  bit   in_run = 0;
  int   r_dig, r_seg, r_len, r_start;

  initial begin
    forever begin
      @(negedge clk);
      if (o_tick === 1'b1) tick_q.push_back(cyc);
      if (o_digit !== 4'hF) begin
        if (in_run && int'(o_digit) != r_dig) begin
          run_dig_q.push_back(r_dig); run_seg_q.push_back(r_seg);
          run_len_q.push_back(r_len); run_start_q.push_back(r_start);
          in_run = 0;
        end
        if (!in_run) begin
          in_run = 1; r_dig = int'(o_digit); r_seg = int'(o_seg);
          r_len = 1; r_start = cyc;
        end else begin
          r_len = r_len + 1;
        end
      end else if (in_run) begin
        run_dig_q.push_back(r_dig); run_seg_q.push_back(r_seg);
        run_len_q.push_back(r_len); run_start_q.push_back(r_start);
        in_run = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_run(input string name, input int i, input int dig, input int seg, input int len);
    if (i >= run_dig_q.size()) begin
      chk({name, "_present"}, run_dig_q.size(), i + 1);
    end else begin
      chk({name, "_digit"}, run_dig_q[i], dig);
      chk({name, "_seg"},   run_seg_q[i], seg);
      chk({name, "_len"},   run_len_q[i], len);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_dig[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    int seg_1234[4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    int seg_abcd[4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    int seg_dp[4]   = '{8'h99, 8'hB0, 8'h24, 8'hF9};

    rst = 1'b1; en = 1'b1; value = 16'h1234; dp = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_digit", int'(o_digit), 4'hF);
    chk("reset_seg",   int'(o_seg),   8'hFF);
    chk("reset_tick",  int'(o_tick),  0);

    // Release reset; the next edge is E0.
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);          // through E0+39: mid frame 1
    #1 value = 16'hABCD;
    repeat (58) @(posedge clk);          // through E0+97
    @(negedge clk); #1;

    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++)
        chk_run($sformatf("scan_f%0d_d%0d", f, s), 4*f + s, exp_dig[s],
                (f < 2) ? seg_1234[s] : seg_abcd[s], SCAN_DIV - BLANK);
    for (int i = 0; i < 11; i++)
      if (i + 1 < run_start_q.size())
        chk($sformatf("slot_spacing_%0d", i), run_start_q[i+1] - run_start_q[i], SCAN_DIV);

    value = 16'h1234; dp = 4'b0100;      // shown from the frame at E0+128
    repeat (82) @(posedge clk);          // through E0+179: frame 5, digit 2 lit
    #1 en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("disable_digit", int'(o_digit), 4'hF);
    chk("disable_seg",   int'(o_seg),   8'hFF);
    @(posedge clk);
    @(posedge clk); #1 en = 1'b1;        // next edge restarts the scan
    @(posedge clk); @(negedge clk);
    chk("reenable_tick",  int'(o_tick),  1);
    chk("reenable_dark",  int'(o_digit), 4'hF);
    @(posedge clk); @(negedge clk);
    chk("reenable_blank2", int'(o_digit), 4'hF);
    @(posedge clk); @(negedge clk);
    chk("reenable_d0_digit", int'(o_digit), 4'hE);
    chk("reenable_d0_seg",   int'(o_seg),   8'h99);

    value = 16'h0050; dp = 4'b0000;      // shown from E0'+32
    repeat (70) @(posedge clk);
    @(negedge clk); #1;

    for (int s = 0; s < 4; s++)
      chk_run($sformatf("dp_d%0d", s), 16 + s, exp_dig[s], seg_dp[s], SCAN_DIV - BLANK);
    chk_run("cut_d2", 22, 4'hB, 8'h24, 2);
    chk_run("restart_d0", 23, 4'hE, 8'h99, SCAN_DIV - BLANK);
    if (tick_q.size() >= 7 && run_start_q.size() >= 24)
      chk("restart_blank_gap", run_start_q[23] - tick_q[6], BLANK);
    else
      chk("restart_ticks_present", tick_q.size(), 7);

    chk_run("lz_d0", 27, 4'hE, 8'hC0, SCAN_DIV - BLANK);
    chk_run("lz_d1", 28, 4'hD, 8'h92, SCAN_DIV - BLANK);
`ifdef FND_LEADING_ZERO_BLANK_EN
    chk_run("lz_next_d0", 29, 4'hE, 8'hC0, SCAN_DIV - BLANK);
`else
    chk_run("lz_d2", 29, 4'hB, 8'hC0, SCAN_DIV - BLANK);
    chk_run("lz_d3", 30, 4'h7, 8'hC0, SCAN_DIV - BLANK);
`endif

    if (tick_q.size() >= 7) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("tick_period_%0d", i), tick_q[i+1] - tick_q[i], FRAME);
      chk("tick_restart_gap", tick_q[6] - tick_q[5], 23);
    end else begin
      chk("tick_count", tick_q.size(), 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
